// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU RAM-port arbiter slice.
//   DEF_ADDR_W / DEF_DATA_W : default RAM address / data widths (16x8 RAM)
//   arb_state_t             : RAM-port ownership state machine encoding
package cpu_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        CPU_OWN = 2'd0,  // CPU drives the RAM port directly
        DRAIN   = 2'd1,  // CPU stalled, waiting for its in-flight access to end
        LOAD    = 2'd2,  // loader owns the RAM port
        FINISH  = 2'd3   // one-cycle session close, ld_done pulse
    } arb_state_t;

endpackage

// File: rtl/ld_addr_counter.sv
// Load-session write pointer and byte counter.
//   clk, rst   : clock, synchronous active-high reset
//   load       : start of session; ptr <= base, count <= 0
//   base       : first write address of the session
//   inc        : one byte accepted; ptr advances (wrapping), count increments
//   ptr        : current loader write address
//   count      : bytes written this session, 0..2**ADDR_W (saturates at full)
//   last_slot  : the next accepted byte fills the RAM (count == 2**ADDR_W - 1)
module ld_addr_counter
    import cpu_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] base,
    input  logic              inc,
    output logic [ADDR_W-1:0] ptr,
    output logic [ADDR_W:0]   count,
    output logic              last_slot
);

    localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   count_q, count_d;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        if (load) begin
            ptr_d   = base;
            count_d = '0;
        end else if (inc && (count_q != FULL)) begin
            // Pointer wraps naturally at 2**ADDR_W; count stops at full.
            ptr_d   = ptr_q + 1'b1;
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    assign ptr       = ptr_q;
    assign count     = count_q;
    assign last_slot = (count_q == (FULL - 1'b1));

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the 16x8 program/data RAM between the CPU control path and an
// external byte-stream program loader.
//   CPU side    : cpu_addr/cpu_wdata/cpu_ce_n/cpu_we_n in, cpu_rdata out,
//                 cpu_hold freezes the stage sequencer during a load session
//   Loader side : ld_start/ld_base open a session, ld_valid/ld_data/ld_last
//                 stream bytes, ld_ready/ld_busy/ld_done/ld_count report status
//   RAM side    : ram_addr/ram_wdata/ram_ce/ram_we out (active-high), ram_rdata in
module ram_port_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_ce_n,
    input  logic              cpu_we_n,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_hold,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              ld_busy,
    output logic              ld_done,
    output logic [ADDR_W:0]   ld_count,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_ce,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);

    arb_state_t        state_q, state_d;
    logic              ctr_load;
    logic              ctr_inc;
    logic              accept;
    logic              last_slot;
    logic [ADDR_W-1:0] ptr;

    ld_addr_counter #(.ADDR_W(ADDR_W)) u_ctr (
        .clk       (clk),
        .rst       (rst),
        .load      (ctr_load),
        .base      (ld_base),
        .inc       (ctr_inc),
        .ptr       (ptr),
        .count     (ld_count),
        .last_slot (last_slot)
    );

    // The loader never reads, so read data always goes straight to the CPU.
    assign cpu_rdata = ram_rdata;

    always_comb begin
        state_d   = state_q;
        cpu_hold  = 1'b0;
        ld_ready  = 1'b0;
        ld_busy   = 1'b0;
        ld_done   = 1'b0;
        ctr_load  = 1'b0;
        ctr_inc   = 1'b0;
        accept    = 1'b0;
        // CPU owns the port unless a state below overrides it.
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        ram_ce    = ~cpu_ce_n;
        ram_we    = ~cpu_we_n & ~cpu_ce_n;

        unique case (state_q)
            CPU_OWN: begin
                if (ld_start) begin
                    state_d  = DRAIN;
                    ctr_load = 1'b1;
                end
            end
            DRAIN: begin
                // CPU keeps the port so an access already under way can finish.
                cpu_hold = 1'b1;
                ld_busy  = 1'b1;
                if (cpu_ce_n) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cpu_hold  = 1'b1;
                ld_busy   = 1'b1;
                ld_ready  = 1'b1;
                accept    = ld_valid;
                ram_addr  = ptr;
                ram_wdata = ld_data;
                ram_ce    = accept;
                ram_we    = accept;
                ctr_inc   = accept;
                if (accept && (ld_last || last_slot)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                cpu_hold = 1'b1;
                ld_busy  = 1'b1;
                ld_done  = 1'b1;
                ram_ce   = 1'b0;
                ram_we   = 1'b0;
                state_d  = CPU_OWN;
            end
            default: begin
                state_d = CPU_OWN;
            end
        endcase
    end

    // NOTE: reset is synchronous, so rst only takes effect on a clock edge and overrides any same-cycle ld_start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CPU_OWN;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: behavioural 16x8 RAM, a write
// scoreboard fed by the stimulus and drained by the RAM-side monitor, plus
// direct checks of the control/status outputs.
module tb_ram_port_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       cpu_ce_n;
    logic       cpu_we_n;
    logic [7:0] cpu_rdata;
    logic       cpu_hold;
    logic       ld_start;
    logic [3:0] ld_base;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_last;
    logic       ld_ready;
    logic       ld_busy;
    logic       ld_done;
    logic [4:0] ld_count;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata;
    logic       ram_ce;
    logic       ram_we;
    logic [7:0] ram_rdata;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_e;
    logic [7:0] mem [16];
    logic [3:0] exp_ptr;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    ram_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ce_n  (cpu_ce_n),
        .cpu_we_n  (cpu_we_n),
        .cpu_rdata (cpu_rdata),
        .cpu_hold  (cpu_hold),
        .ld_start  (ld_start),
        .ld_base   (ld_base),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .ld_ready  (ld_ready),
        .ld_busy   (ld_busy),
        .ld_done   (ld_done),
        .ld_count  (ld_count),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_ce    (ram_ce),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata)
    );

    assign ram_rdata = mem[ram_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Writes are sampled mid-cycle, away from the edge where inputs change.
    always @(negedge clk) begin
        if (ram_ce && ram_we) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_write", 32'(ram_addr), 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_addr", 32'(ram_addr), 32'(mon_e.addr));
                check("sb_data", 32'(ram_wdata), 32'(mon_e.data));
            end
            mem[ram_addr] = ram_wdata;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before time 100000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_session(input logic [3:0] base);
        ld_start = 1'b1;
        ld_base  = base;
        exp_ptr  = base;
        tick();
        ld_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        exp_q.push_back('{addr: exp_ptr, data: d});
        exp_ptr  = exp_ptr + 4'd1;
        #1 check("send_ready", 32'(ld_ready), 1);
        tick();
    endtask

    task automatic cpu_read(input logic [3:0] a, input logic [7:0] exp, input string tag);
        cpu_ce_n = 1'b0;
        cpu_we_n = 1'b1;
        cpu_addr = a;
        #1 check(tag, 32'(cpu_rdata), 32'(exp));
        tick();
        cpu_ce_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        rst = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_ce_n = 1'b1; cpu_we_n = 1'b1;
        ld_start = 1'b0; ld_base = '0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
        exp_ptr = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_hold",  32'(cpu_hold), 0);
        check("rst_ready", 32'(ld_ready), 0);
        check("rst_busy",  32'(ld_busy),  0);
        check("rst_done",  32'(ld_done),  0);
        check("rst_count", 32'(ld_count), 0);
        tick();

        // 1: idle CPU write passes straight through
        cpu_ce_n = 1'b0; cpu_we_n = 1'b0; cpu_addr = 4'h3; cpu_wdata = 8'hA5;
        exp_q.push_back('{addr: 4'h3, data: 8'hA5});
        #1;
        check("idle_we",   32'(ram_we),   1);
        check("idle_ce",   32'(ram_ce),   1);
        check("idle_addr", 32'(ram_addr), 3);
        check("idle_hold", 32'(cpu_hold), 0);
        tick();
        cpu_ce_n = 1'b1; cpu_we_n = 1'b1;
        cpu_read(4'h3, 8'hA5, "idle_readback");

        // 2: basic session, base 2, three bytes ending with ld_last
        start_session(4'h2);
        #1;
        check("drain_busy",  32'(ld_busy),  1);
        check("drain_hold",  32'(cpu_hold), 1);
        check("drain_ready", 32'(ld_ready), 0);
        tick();
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b1);
        ld_valid = 1'b0; ld_last = 1'b0;
        #1;
        check("fin_done",  32'(ld_done),  1);
        check("fin_hold",  32'(cpu_hold), 1);
        check("fin_ready", 32'(ld_ready), 0);
        check("fin_count", 32'(ld_count), 3);
        tick();
        check("post_hold",  32'(cpu_hold), 0);
        check("post_done",  32'(ld_done),  0);
        check("post_busy",  32'(ld_busy),  0);
        check("post_count", 32'(ld_count), 3);
        cpu_read(4'h2, 8'h11, "rd_2");
        cpu_read(4'h3, 8'h22, "rd_3");
        cpu_read(4'h4, 8'h33, "rd_4");

        // 3: session opened while a CPU read is in flight
        cpu_ce_n = 1'b0; cpu_we_n = 1'b1; cpu_addr = 4'h1;
        start_session(4'h8);
        #1;
        check("drain1_ready", 32'(ld_ready), 0);
        check("drain1_ce",    32'(ram_ce),   1);
        tick();
        check("drain2_ready", 32'(ld_ready), 0);
        check("drain2_busy",  32'(ld_busy),  1);
        cpu_ce_n = 1'b1;
        tick();
        check("load_after_drain", 32'(ld_ready), 1);
        send(8'h5C, 1'b1);
        ld_valid = 1'b0; ld_last = 1'b0;
        tick();
        cpu_read(4'h8, 8'h5C, "rd_8");

        // 4: wrap from F to 0; ld_start during LOAD must be ignored
        start_session(4'hE);
        tick();
        send(8'hA1, 1'b0);
        ld_valid = 1'b0; ld_start = 1'b1; ld_base = 4'h7;
        tick();
        ld_start = 1'b0;
        #1 check("start_ignored_busy", 32'(ld_busy), 1);
        send(8'hA2, 1'b0);
        send(8'hA3, 1'b1);
        ld_valid = 1'b0; ld_last = 1'b0;
        #1 check("wrap_count", 32'(ld_count), 3);
        tick();
        cpu_read(4'hF, 8'hA2, "rd_F");
        cpu_read(4'h0, 8'hA3, "rd_0");

        // 5: fill all 16 locations without ld_last
        start_session(4'h0);
        tick();
        for (int i = 0; i < 16; i++) send(8'h40 + 8'(i), 1'b0);
        ld_valid = 1'b1; ld_data = 8'hFF;
        #1;
        check("full_ready", 32'(ld_ready), 0);
        check("full_we",    32'(ram_we),   0);
        check("full_done",  32'(ld_done),  1);
        check("full_count", 32'(ld_count), 16);
        tick();
        ld_valid = 1'b0;
        #1;
        check("full_busy_after",  32'(ld_busy),  0);
        check("full_count_hold",  32'(ld_count), 16);
        tick();

        // 6: reset mid-session keeps written bytes
        start_session(4'h5);
        tick();
        send(8'h61, 1'b0);
        send(8'h62, 1'b0);
        ld_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("midrst_hold",  32'(cpu_hold), 0);
        check("midrst_busy",  32'(ld_busy),  0);
        check("midrst_count", 32'(ld_count), 0);
        check("midrst_ready", 32'(ld_ready), 0);
        tick();
        cpu_read(4'h5, 8'h61, "rd_5");
        cpu_read(4'h6, 8'h62, "rd_6");
        cpu_read(4'h7, 8'h47, "rd_7");

        // CPU write strobes are ignored while the loader owns the port
        start_session(4'h9);
        tick();
        cpu_ce_n = 1'b0; cpu_we_n = 1'b0; cpu_addr = 4'h9; cpu_wdata = 8'hEE;
        #1;
        check("load_cpu_ce", 32'(ram_ce), 0);
        check("load_cpu_we", 32'(ram_we), 0);
        tick();
        cpu_ce_n = 1'b1; cpu_we_n = 1'b1;
        send(8'h77, 1'b1);
        ld_valid = 1'b0; ld_last = 1'b0;
        tick();
        cpu_read(4'h9, 8'h77, "rd_9");

        // rst and ld_start in the same cycle: reset wins
        rst = 1'b1; ld_start = 1'b1; ld_base = 4'h3;
        tick();
        rst = 1'b0; ld_start = 1'b0;
        #1;
        check("rstwin_busy", 32'(ld_busy),  0);
        check("rstwin_hold", 32'(cpu_hold), 0);
        tick();
        check("rstwin_busy2", 32'(ld_busy), 0);

        check("sb_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
